// File: rtl/pf_req_queue_pkg.sv
// Shared frontend prefetch definitions.
// Provides the default physical-address / line-offset widths, the line-tag
// type used wherever a cache line is identified, and the issue-FSM states.
package pf_req_queue_pkg;

  localparam int PF_ADDR_W = 32;
  localparam int PF_OFF_W  = 6;   // 64-byte lines
  localparam int PF_TAG_W  = PF_ADDR_W - PF_OFF_W;

  typedef logic [PF_TAG_W-1:0] line_tag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } pf_state_e;

endpackage

// File: rtl/pf_req_queue_if.sv
// Prefetch request interface between frontend stage 1, the prefetch queue
// and the L2/memory fill port.
//
// Handshake rules:
//   - bppf_valid / nlpf_valid are single-cycle offers; there is no ready,
//     the queue either takes a request or drops it in that same cycle.
//   - mem_req_valid / mem_req_ready is a strict valid/ready pair: a transfer
//     happens on a cycle where both are 1. Once mem_req_valid rises, it and
//     mem_req_addr hold stable until the transfer, except that a flush may
//     withdraw a request that has not yet been accepted.
//   - mem_resp_valid is a one-cycle pulse completing the single outstanding
//     fill; it is ignored when no fill is outstanding.
//
// Modports: slave = the prefetch queue, master = the frontend / fill side.
// issue_state is a debug view of the issue FSM.
interface pf_req_queue_if #(
  parameter int ADDR_W = pf_req_queue_pkg::PF_ADDR_W,
  parameter int DEPTH  = 4
);
  import pf_req_queue_pkg::*;

  logic                         bppf_valid;
  logic [ADDR_W-1:0]            bppf_paddr;
  logic                         nlpf_valid;
  logic [ADDR_W-1:0]            nlpf_paddr;
  logic                         flush;
  logic                         mem_req_valid;
  logic [ADDR_W-1:0]            mem_req_addr;
  logic                         mem_req_ready;
  logic                         mem_resp_valid;
  logic [$clog2(DEPTH+1)-1:0]   pf_count;
  logic                         pf_full;
  logic [7:0]                   drop_cnt;
  pf_state_e                    issue_state;

  modport slave (
    input  bppf_valid, bppf_paddr, nlpf_valid, nlpf_paddr, flush,
    input  mem_req_ready, mem_resp_valid,
    output mem_req_valid, mem_req_addr, pf_count, pf_full, drop_cnt,
    output issue_state
  );

  modport master (
    output bppf_valid, bppf_paddr, nlpf_valid, nlpf_paddr, flush,
    output mem_req_ready, mem_resp_valid,
    input  mem_req_valid, mem_req_addr, pf_count, pf_full, drop_cnt,
    input  issue_state
  );

endinterface

// File: rtl/pf_req_queue_fifo_cam.sv
// pf_fifo_cam: DEPTH-entry circular FIFO of line tags with two write ports
// and a per-entry tag compare used for duplicate detection.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               empty the FIFO at the next edge (wins over all else)
//   wr_a_en / wr_a_tag  first write port (older request)
//   wr_b_en / wr_b_tag  second write port (lands behind port A when both fire)
//   rd_en               pop the head entry
//   cmp_a_tag/cmp_b_tag tags compared against every valid entry
//   match_a / match_b   per-entry hit vectors for the two compare tags
//   head_tag            tag at the head of the FIFO
//   count               number of valid entries (registered)
//
// The caller never writes more entries than were free at the start of the
// cycle, so a write never lands on the slot being popped.
module pf_fifo_cam #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 26,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_a_en,
  input  logic [TAG_W-1:0] wr_a_tag,
  input  logic             wr_b_en,
  input  logic [TAG_W-1:0] wr_b_tag,
  input  logic             rd_en,
  input  logic [TAG_W-1:0] cmp_a_tag,
  input  logic [TAG_W-1:0] cmp_b_tag,
  output logic [DEPTH-1:0] match_a,
  output logic [DEPTH-1:0] match_b,
  output logic [TAG_W-1:0] head_tag,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] tags [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_b_ptr;

  // Port B goes into the slot after port A only when A also writes.
  assign wr_b_ptr = wr_ptr + PTR_W'(wr_a_en);
  assign head_tag = tags[rd_ptr];

  // Tag storage needs no reset: entries are qualified by valid.
  always_ff @(posedge clk) begin
    if (wr_a_en) tags[wr_ptr]   <= wr_a_tag;
    if (wr_b_en) tags[wr_b_ptr] <= wr_b_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rd_en) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (wr_a_en) valid[wr_ptr]   <= 1'b1;
      if (wr_b_en) valid[wr_b_ptr] <= 1'b1;
      wr_ptr <= wr_ptr + PTR_W'(wr_a_en) + PTR_W'(wr_b_en);
      count  <= count - CNT_W'(rd_en) + CNT_W'(wr_a_en) + CNT_W'(wr_b_en);
    end
  end

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = valid[i] && (tags[i] == cmp_a_tag);
      match_b[i] = valid[i] && (tags[i] == cmp_b_tag);
    end
  end

endmodule

// File: rtl/pf_req_queue.sv
// pf_req_queue: consumer end of the frontend prefetch path.
// Takes branch-predictor (bppf) and next-line (nlpf) prefetch addresses,
// drops requests whose line is already queued or in flight, buffers the rest
// and issues them one at a time to the fill port, tracking one outstanding
// fill until its response pulse.
//
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  pf_req_queue_if.slave: prefetch inputs, flush, fill request /
//        response handshake, pf_count, pf_full, drop_cnt, issue_state
module pf_req_queue
  import pf_req_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = PF_ADDR_W,
  parameter int OFF_W  = PF_OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  pf_req_queue_if.slave     bus
);

  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  pf_state_e        state;
  pf_state_e        state_next;
  logic [TAG_W-1:0] bppf_tag;
  logic [TAG_W-1:0] nlpf_tag;
  logic [TAG_W-1:0] head_tag;
  logic [TAG_W-1:0] inflight_tag;
  logic [DEPTH-1:0] match_bppf;
  logic [DEPTH-1:0] match_nlpf;
  logic [CNT_W-1:0] count;
  logic             inflight_live;
  logic             bppf_dup;
  logic             nlpf_dup;
  logic             bppf_enq;
  logic             nlpf_enq;
  logic             bppf_drop;
  logic             nlpf_drop;
  logic             pop;
  logic             nonempty_next;
  logic [1:0]       drop_n;
  logic [8:0]       drop_sum;
  logic [7:0]       drop_cnt_q;
  logic             unused_offset_bits;

  assign bppf_tag = bus.bppf_paddr[ADDR_W-1:OFF_W];
  assign nlpf_tag = bus.nlpf_paddr[ADDR_W-1:OFF_W];
  assign unused_offset_bits = ^{bus.bppf_paddr[OFF_W-1:0], bus.nlpf_paddr[OFF_W-1:0]};

  // The in-flight tag only guards against duplicates while a fill is pending.
  assign inflight_live = (state == WAIT);
  assign pop           = (state == REQ) && bus.mem_req_ready;

  // Enqueue / drop decisions. Capacity is judged on the occupancy at the
  // start of the cycle, so a slot freed by this cycle's pop is not reused.
  // A flush suppresses enqueues without counting them as drops.
  always_comb begin
    bppf_dup = (|match_bppf) || (inflight_live && (bppf_tag == inflight_tag));
    nlpf_dup = (|match_nlpf) || (inflight_live && (nlpf_tag == inflight_tag))
               || (bus.bppf_valid && (nlpf_tag == bppf_tag));
    bppf_enq = bus.bppf_valid && !bus.flush && !bppf_dup
               && (count < CNT_W'(DEPTH));
    nlpf_enq = bus.nlpf_valid && !bus.flush && !nlpf_dup
               && ((count + CNT_W'(bppf_enq)) < CNT_W'(DEPTH));
    bppf_drop = bus.bppf_valid && !bus.flush && !bppf_enq;
    nlpf_drop = bus.nlpf_valid && !bus.flush && !nlpf_enq;
    drop_n    = {1'b0, bppf_drop} + {1'b0, nlpf_drop};
    drop_sum  = {1'b0, drop_cnt_q} + {7'b0, drop_n};
    // Used only from IDLE/WAIT, where nothing is popped.
    nonempty_next = !bus.flush && ((count != '0) || bppf_enq || nlpf_enq);
  end

  pf_fifo_cam #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .wr_a_en   (bppf_enq),
    .wr_a_tag  (bppf_tag),
    .wr_b_en   (nlpf_enq),
    .wr_b_tag  (nlpf_tag),
    .rd_en     (pop),
    .cmp_a_tag (bppf_tag),
    .cmp_b_tag (nlpf_tag),
    .match_a   (match_bppf),
    .match_b   (match_nlpf),
    .head_tag  (head_tag),
    .count     (count)
  );

  // Issue FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Issue FSM: next state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (nonempty_next) state_next = REQ;
      // An accepted handshake always stands, even under flush; an
      // unaccepted request is withdrawn only by a flush.
      REQ: begin
        if (bus.mem_req_ready) state_next = WAIT;
        else if (bus.flush)    state_next = IDLE;
      end
      WAIT: if (bus.mem_resp_valid) state_next = nonempty_next ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue FSM: outputs.
  always_comb begin
    bus.mem_req_valid = (state == REQ);
    bus.mem_req_addr  = (state == REQ) ? {head_tag, {OFF_W{1'b0}}} : '0;
    bus.issue_state   = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_tag <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (pop)                                     inflight_tag <= head_tag;
      else if (inflight_live && bus.mem_resp_valid) inflight_tag <= '0;
      drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign bus.pf_count = count;
  assign bus.pf_full  = (count == CNT_W'(DEPTH));
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pf_req_queue.sv
// Testbench for pf_req_queue: directed scenarios plus a randomized run,
// every cycle checked against a queue-level reference model.
module tb_pf_req_queue;
  import pf_req_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = PF_ADDR_W;
  localparam int OW    = PF_OFF_W;
  localparam int TW    = PF_TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pf_req_queue_if #(.ADDR_W(AW), .DEPTH(DEPTH)) ifc ();

  pf_req_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .OFF_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // ---------------- reference model ----------------
  // exp_q holds queued line tags in issue order; m_pres = a request is being
  // offered, m_busy = a fill is outstanding for m_btag.
  logic [TW-1:0] exp_q[$];
  bit            m_pres;
  bit            m_busy;
  logic [TW-1:0] m_btag;
  int            m_drop;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pres = 0;
    m_busy = 0;
    m_btag = '0;
    m_drop = 0;
  endtask

  function automatic bit known_line(input logic [TW-1:0] t);
    foreach (exp_q[i]) if (exp_q[i] == t) return 1'b1;
    return m_busy && (t == m_btag);
  endfunction

  // Advance the model by one clock using the inputs applied for that cycle.
  task automatic model_step();
    logic [TW-1:0] bt;
    logic [TW-1:0] nt;
    logic [TW-1:0] add_q[$];
    bit            hs;
    bt = ifc.bppf_paddr[AW-1:OW];
    nt = ifc.nlpf_paddr[AW-1:OW];
    if (!ifc.flush) begin
      if (ifc.bppf_valid) begin
        if (known_line(bt) || exp_q.size() >= DEPTH) m_drop++;
        else add_q.push_back(bt);
      end
      if (ifc.nlpf_valid) begin
        if (known_line(nt) || (ifc.bppf_valid && nt == bt) ||
            (exp_q.size() + add_q.size()) >= DEPTH) m_drop++;
        else add_q.push_back(nt);
      end
    end
    if (m_drop > 255) m_drop = 255;
    hs = m_pres && ifc.mem_req_ready;
    if (hs) m_btag = exp_q.pop_front();
    if (ifc.flush) exp_q.delete();
    else foreach (add_q[i]) exp_q.push_back(add_q[i]);
    if (hs) begin
      m_pres = 0;
      m_busy = 1;
    end else if (m_pres) begin
      m_pres = !ifc.flush;
    end else if (m_busy) begin
      if (ifc.mem_resp_valid) begin
        m_busy = 0;
        m_pres = (exp_q.size() != 0);
      end
    end else begin
      m_pres = (exp_q.size() != 0);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    logic [31:0] exp_addr;
    pf_state_e   exp_st;
    exp_addr = m_pres ? {exp_q[0], {OW{1'b0}}} : 32'h0;
    exp_st   = m_pres ? REQ : (m_busy ? WAIT : IDLE);
    chk("req_valid", 32'(ifc.mem_req_valid), 32'(m_pres));
    chk("req_addr",  ifc.mem_req_addr, exp_addr);
    chk("pf_count",  32'(ifc.pf_count), 32'(exp_q.size()));
    chk("pf_full",   32'(ifc.pf_full), 32'(exp_q.size() == DEPTH));
    chk("drop_cnt",  32'(ifc.drop_cnt), 32'(m_drop));
    chk("state",     32'(ifc.issue_state), 32'(exp_st));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic bv, input logic [31:0] ba, input logic nv,
                        input logic [31:0] na, input logic fl, input logic rdy,
                        input logic resp);
    ifc.bppf_valid     = bv;
    ifc.bppf_paddr     = ba;
    ifc.nlpf_valid     = nv;
    ifc.nlpf_paddr     = na;
    ifc.flush          = fl;
    ifc.mem_req_ready  = rdy;
    ifc.mem_resp_valid = resp;
  endtask

  // Called at a falling edge: apply inputs, clock once, check at next fall.
  task automatic step(input logic bv, input logic [31:0] ba, input logic nv,
                      input logic [31:0] na, input logic fl, input logic rdy,
                      input logic resp);
    set_in(bv, ba, nv, na, fl, rdy, resp);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 5)) << OW)
           | 32'($urandom_range(0, 63));
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    apply_reset();
    chk("reset_valid", 32'(ifc.mem_req_valid), 32'd0);
    chk("reset_state", 32'(ifc.issue_state), 32'(IDLE));

    // Single request through a full fill.
    step(1'b1, 32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("single_valid", 32'(ifc.mem_req_valid), 32'd1);
    chk("single_addr", ifc.mem_req_addr, 32'h0000_1200);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("single_wait", 32'(ifc.issue_state), 32'(WAIT));
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("single_idle", 32'(ifc.issue_state), 32'(IDLE));
    chk("single_count", 32'(ifc.pf_count), 32'd0);

    // Same-line pair in one cycle, then a new line behind it.
    apply_reset();
    step(1'b1, 32'h1000, 1'b1, 32'h1020, 1'b0, 1'b0, 1'b0);
    chk("dual_count", 32'(ifc.pf_count), 32'd1);
    chk("dual_drop", 32'(ifc.drop_cnt), 32'd1);
    chk("dual_addr", ifc.mem_req_addr, 32'h1000);
    step(1'b0, 32'h0, 1'b1, 32'h1040, 1'b0, 1'b1, 1'b0);
    chk("dual_wait", 32'(ifc.issue_state), 32'(WAIT));
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("dual_second", ifc.mem_req_addr, 32'h1040);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Fill to full, overflow drops, drop counter saturation, issue order.
    apply_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 32'(k) * 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("full_flag", 32'(ifc.pf_full), 32'd1);
    step(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("full_drop", 32'(ifc.drop_cnt), 32'd1);
    for (int k = 0; k < 140; k++) step(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    chk("drop_sat", 32'(ifc.drop_cnt), 32'd255);
    for (int k = 1; k <= 4; k++) begin
      chk("issue_order", ifc.mem_req_addr, 32'(k) * 32'h100);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    chk("order_idle", 32'(ifc.issue_state), 32'(IDLE));

    // Duplicate of the in-flight line.
    apply_reset();
    step(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h2010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("inflight_drop", 32'(ifc.drop_cnt), 32'd1);
    chk("inflight_cnt", 32'(ifc.pf_count), 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h2010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("inflight_requeue", 32'(ifc.pf_count), 32'd1);
    chk("inflight_addr", ifc.mem_req_addr, 32'h2000);

    // Flush while offering: ready low retracts, ready high completes.
    apply_reset();
    step(1'b1, 32'h3000, 1'b1, 32'h3040, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3080, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_pre", 32'(ifc.pf_count), 32'd3);
    step(1'b1, 32'h3100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_valid", 32'(ifc.mem_req_valid), 32'd0);
    chk("flush_count", 32'(ifc.pf_count), 32'd0);
    chk("flush_idle", 32'(ifc.issue_state), 32'(IDLE));
    chk("flush_nodrop", 32'(ifc.drop_cnt), 32'd0);
    step(1'b1, 32'h3000, 1'b1, 32'h3040, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3080, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("flush_hs_wait", 32'(ifc.issue_state), 32'(WAIT));
    chk("flush_hs_count", 32'(ifc.pf_count), 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("flush_hs_idle", 32'(ifc.issue_state), 32'(IDLE));

    // Asynchronous reset while a fill is outstanding.
    apply_reset();
    step(1'b1, 32'h4000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h4040, 1'b1, 32'h4000, 1'b0, 1'b0, 1'b0);
    chk("arst_pre_cnt", 32'(ifc.pf_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ifc.mem_req_valid), 32'd0);
    chk("arst_count", 32'(ifc.pf_count), 32'd0);
    chk("arst_drop", 32'(ifc.drop_cnt), 32'd0);
    chk("arst_state", 32'(ifc.issue_state), 32'(IDLE));
    model_reset();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("arst_resp_ignored", 32'(ifc.issue_state), 32'(IDLE));
    idle_step();

    // Randomized traffic.
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pf_req_queue.md
Name: pf_req_queue

Overview:
- Consumer end of the frontend prefetch interface. Accepts branch-predictor (bppf) and next-line (nlpf) prefetch physical addresses from frontend stage 1.
- Drops duplicates, buffers requests in a small FIFO and issues them one at a time to the L2/memory fill port over a valid/ready handshake.
- Tracks a single outstanding fill until it completes.
- Sits between frontend stage 1 and the I-cache fill path.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_W, 32, physical address width
OFF_W, 6, line-offset bits (64 B lines); line tag = paddr[ADDR_W-1:OFF_W]

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
bppf_valid  in  1  branch-predictor prefetch request valid
bppf_paddr  in  ADDR_W  branch-predictor prefetch physical address
nlpf_valid  in  1  next-line prefetch request valid
nlpf_paddr  in  ADDR_W  next-line prefetch physical address
flush  in  1  frontend redirect; discard queued prefetches
mem_req_valid  out  1  fill request valid
mem_req_addr  out  ADDR_W  line-aligned fill address {tag, OFF_W'b0}
mem_req_ready  in  1  fill port accepts the request
mem_resp_valid  in  1  outstanding fill complete (one pulse per request)
pf_count  out  $clog2(DEPTH+1)  number of queued entries
pf_full  out  1  pf_count == DEPTH
drop_cnt  out  8  saturating count of dropped requests

Behaviour:
- Reset: queue empty, FSM in IDLE, all outputs 0.
- Enqueue, same cycle as input valid; entry visible at the head the next cycle.
  - Order: bppf, then nlpf.
  - A request is dropped (drop_cnt += 1, saturating at 255) if its line tag matches any valid queue entry or the in-flight tag (WAIT state).
  - If bppf and nlpf carry the same tag, only bppf is enqueued; nlpf counts as dropped.
  - Only one free slot: bppf enqueued, nlpf dropped. Zero free slots: both dropped.
  - A slot freed by a pop in the same cycle is not reusable until the next cycle.
- Issue FSM:
  - IDLE -> REQ when the queue is non-empty.
  - REQ: mem_req_valid=1, mem_req_addr = head tag, OFF_W'b0. The request stays stable until the handshake completes.
  - REQ with ready=1: pop the head, latch its tag as in-flight, go to WAIT.
  - WAIT: mem_req_valid=0. On mem_resp_valid, clear the in-flight tag and go to REQ if the queue is non-empty after this cycle's enqueue, else IDLE.
  - mem_resp_valid outside WAIT is ignored.
- Flush:
  - Empties the queue next cycle; enqueues in the flush cycle are suppressed and not counted as drops.
  - REQ with flush and ready=0: retract to IDLE. This is the only legal retraction.
  - REQ with flush and ready=1: the handshake counts; go to WAIT.
  - WAIT is unaffected; the fill still completes.
- Dedup compares the tags of queue entries valid at the start of the cycle, plus the in-flight tag.
- pf_count and pf_full are registered and reflect the end of the previous cycle.
- Reset asserted mid-operation: immediate return to the reset state; any pending fill response is lost and later ignored.

Decomposition:
- Shared frontend package: OFF_W/line-size constant, line-tag typedef (ADDR_W-OFF_W bits), issue-FSM state enum {IDLE, REQ, WAIT}.
- One sub-module, pf_fifo_cam: DEPTH-entry circular FIFO with two write ports and a per-entry tag-match output for dedup. The issue FSM and drop counter stay in the top.

Test Plan:
- Single request: bppf_valid=1, paddr 0x0000_1234; ready=1 -> next cycle mem_req_valid=1, addr 0x0000_1200; in WAIT, a mem_resp_valid pulse -> IDLE, pf_count=0.
- Dual with dedup: bppf 0x1000 and nlpf 0x1020 in the same cycle -> one entry queued (tag 0x40), drop_cnt=1. Then nlpf 0x1040 -> enqueued, issued after the first fill completes.
- Fill to full: ready=0, four distinct lines 0x100, 0x200, 0x300, 0x400 -> pf_full=1. A fifth request 0x500 -> dropped, drop_cnt=1. Then raise ready -> issue order 0x100, 0x200, 0x300, 0x400.
- In-flight dedup: in WAIT on line 0x2000, bppf 0x2010 -> dropped. After the response, bppf 0x2010 -> enqueued.
- Flush: three entries queued, REQ with ready=0, flush=1 -> next cycle mem_req_valid=0, pf_count=0, IDLE. Repeat with ready=1 in the flush cycle -> WAIT, the in-flight fill completes normally.
- Async reset in WAIT: assert rst between edges -> outputs 0 immediately. A later mem_resp_valid is ignored and the FSM stays IDLE.
